// File: rtl/vga_sram_reader.sv
// Frame-buffer read side: VGA raster timing, sequential SRAM reads in step with the raster,
// and pixel/sync/de outputs aligned once the SRAM read latency has elapsed.
module vga_sram_reader #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned CNT_WIDTH  = 10,
  parameter int unsigned ADDR_WIDTH = 19,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RD_LAT     = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_frame_ready,
  output logic [ADDR_WIDTH-1:0] o_sram_addr,
  output logic                  o_sram_rd_en,
  input  logic [DATA_WIDTH-1:0] i_sram_data,
  output logic [DATA_WIDTH-1:0] o_pixel,
  output logic                  o_de,
  output logic                  o_hsync,
  output logic                  o_vsync,
  output logic                  o_frame_done
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_WIDTH-1:0] H_LAST   = CNT_WIDTH'(H_TOTAL - 1);
  localparam logic [CNT_WIDTH-1:0] V_LAST   = CNT_WIDTH'(V_TOTAL - 1);
  localparam logic [CNT_WIDTH-1:0] H_VIS    = CNT_WIDTH'(H_ACTIVE);
  localparam logic [CNT_WIDTH-1:0] V_VIS    = CNT_WIDTH'(V_ACTIVE);
  localparam logic [CNT_WIDTH-1:0] H_HS_BEG = CNT_WIDTH'(H_ACTIVE + H_FP);
  localparam logic [CNT_WIDTH-1:0] H_HS_END = CNT_WIDTH'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_WIDTH-1:0] V_VS_BEG = CNT_WIDTH'(V_ACTIVE + V_FP);
  localparam logic [CNT_WIDTH-1:0] V_VS_END = CNT_WIDTH'(V_ACTIVE + V_FP + V_SYNC - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SCAN} state_t;

  state_t                state;
  logic [CNT_WIDTH-1:0]  h;
  logic [CNT_WIDTH-1:0]  v;
  logic [RD_LAT:0]       vis_pipe;
  logic [RD_LAT:0]       hs_pipe;
  logic [RD_LAT:0]       vs_pipe;

  logic                  h_wrap;
  logic                  v_wrap;
  logic                  start;
  logic                  nxt_live;
  logic [CNT_WIDTH-1:0]  nxt_h;
  logic [CNT_WIDTH-1:0]  nxt_v;
  logic [ADDR_WIDTH-1:0] nxt_addr;

  function automatic logic vis_at(input logic [CNT_WIDTH-1:0] hh, input logic [CNT_WIDTH-1:0] vv);
    return (hh < H_VIS) && (vv < V_VIS);
  endfunction

  function automatic logic hsync_at(input logic [CNT_WIDTH-1:0] hh);
    return (hh >= H_HS_BEG) && (hh <= H_HS_END);
  endfunction

  function automatic logic vsync_at(input logic [CNT_WIDTH-1:0] vv);
    return (vv >= V_VS_BEG) && (vv <= V_VS_END);
  endfunction

  // h/v/addr always describe the pixel whose read strobe is on the bus this cycle,
  // so the registered strobe, address and pipeline head are loaded from the successor position.
  always_comb begin
    h_wrap   = (h == H_LAST);
    v_wrap   = (v == V_LAST);
    start    = i_en && i_frame_ready && ((state == S_IDLE) || (state == S_WAIT));
    nxt_live = start || ((state == S_SCAN) && !(h_wrap && v_wrap && !i_en));
    nxt_h    = h_wrap ? '0 : h + CNT_WIDTH'(1);
    nxt_v    = v;
    nxt_addr = o_sram_addr + (vis_at(h, v) ? ADDR_WIDTH'(1) : '0);
    if (h_wrap) begin
      nxt_v = v_wrap ? '0 : v + CNT_WIDTH'(1);
    end
    if (h_wrap && v_wrap) begin
      nxt_addr = '0;
    end
    if (start) begin
      nxt_h    = '0;
      nxt_v    = '0;
      nxt_addr = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= S_IDLE;
      h            <= '0;
      v            <= '0;
      o_sram_addr  <= '0;
      vis_pipe     <= '0;
      hs_pipe      <= '1;
      vs_pipe      <= '1;
      o_pixel      <= '0;
      o_de         <= 1'b0;
      o_hsync      <= 1'b1;
      o_vsync      <= 1'b1;
      o_frame_done <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) state <= S_SCAN;
          else if (i_en) state <= S_WAIT;
        end
        S_WAIT: begin
          if (!i_en) state <= S_IDLE;
          else if (start) state <= S_SCAN;
        end
        S_SCAN: begin
          if (!nxt_live) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (nxt_live) begin
        h           <= nxt_h;
        v           <= nxt_v;
        o_sram_addr <= nxt_addr;
      end

      // Outside a scan the pipeline head is fed inactive values so it drains cleanly.
      vis_pipe     <= {vis_pipe[RD_LAT-1:0], nxt_live && vis_at(nxt_h, nxt_v)};
      hs_pipe      <= {hs_pipe[RD_LAT-1:0], !(nxt_live && hsync_at(nxt_h))};
      vs_pipe      <= {vs_pipe[RD_LAT-1:0], !(nxt_live && vsync_at(nxt_v))};
      o_frame_done <= nxt_live && (nxt_h == H_LAST) && (nxt_v == V_LAST);

      o_de    <= vis_pipe[RD_LAT];
      o_pixel <= vis_pipe[RD_LAT] ? i_sram_data : '0;
      o_hsync <= hs_pipe[RD_LAT];
      o_vsync <= vs_pipe[RD_LAT];
    end
  end

  assign o_sram_rd_en = vis_pipe[0];

endmodule

// File: tb/tb_vga_sram_reader.sv
// Bench for vga_sram_reader on a shrunk 8x4 raster with a 2-cycle SRAM model.
module tb_vga_sram_reader;

  localparam int unsigned H_ACT  = 8;
  localparam int unsigned H_TOT  = 14;
  localparam int unsigned V_ACT  = 4;
  localparam int unsigned V_TOT  = 7;
  localparam int unsigned FRAME  = H_TOT * V_TOT;
  localparam int unsigned LAT    = 2;
  localparam int unsigned DISP_D = LAT + 1;

  logic        clk;
  logic        rst;
  logic        en;
  logic        rdy;
  logic [18:0] sram_addr;
  logic        sram_rd_en;
  logic [7:0]  sram_data;
  logic [7:0]  pixel;
  logic        de;
  logic        hsync;
  logic        vsync;
  logic        frame_done;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  vga_sram_reader #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CNT_WIDTH(10), .ADDR_WIDTH(19), .DATA_WIDTH(8), .RD_LAT(2)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_en(en),
    .i_frame_ready(rdy),
    .o_sram_addr(sram_addr),
    .o_sram_rd_en(sram_rd_en),
    .i_sram_data(sram_data),
    .o_pixel(pixel),
    .o_de(de),
    .o_hsync(hsync),
    .o_vsync(vsync),
    .o_frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int mem_at(input int a);
    logic [7:0] b;
    b = 8'(a);
    return int'(b ^ 8'hA5);
  endfunction

  function automatic bit vis_pos(input int p);
    return (p >= 0) && ((p % H_TOT) < H_ACT) && ((p / H_TOT) < V_ACT);
  endfunction

  function automatic int addr_pos(input int p);
    return (p / H_TOT) * H_ACT + (p % H_TOT);
  endfunction

  // SRAM: the byte for a strobe seen in cycle t is presented in cycle t+LAT; junk otherwise.
  bit          sr_en1 = 1'b0;
  bit          sr_en2 = 1'b0;
  logic [18:0] sr_a1 = '0;
  logic [18:0] sr_a2 = '0;
  initial sram_data = 8'h5A;
  always @(negedge clk) begin
    sram_data = sr_en2 ? 8'(mem_at(int'(sr_a2))) : 8'h5A;
    sr_en2 = sr_en1;
    sr_a2  = sr_a1;
    sr_en1 = sram_rd_en;
    sr_a1  = sram_addr;
  end

  // Model: frame position of the current read strobe (-1 when not scanning),
  // with display outputs reflecting the position DISP_D cycles earlier.
  int m_mode = 0;
  int m_pos = -1;
  int m_past [1:DISP_D];
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_mode  = 0;
      m_pos   = -1;
      for (int i = 1; i <= int'(DISP_D); i++) m_past[i] = -1;
      m_valid = 1'b1;
    end else if (m_valid) begin
      for (int i = int'(DISP_D); i > 1; i--) m_past[i] = m_past[i-1];
      m_past[1] = m_pos;
      case (m_mode)
        0: if (en) begin
             if (rdy) begin m_mode = 2; m_pos = 0; end
             else m_mode = 1;
           end
        1: if (!en) m_mode = 0;
           else if (rdy) begin m_mode = 2; m_pos = 0; end
        default: begin
          if (m_pos == int'(FRAME) - 1) begin
            if (en) m_pos = 0;
            else begin m_mode = 0; m_pos = -1; end
          end else begin
            m_pos++;
          end
        end
      endcase
    end
    #1;
    if (m_valid) begin
      int d;
      d = m_past[DISP_D];
      check("rd_en", int'(sram_rd_en), int'(vis_pos(m_pos)));
      if (vis_pos(m_pos)) check("addr", int'(sram_addr), addr_pos(m_pos));
      check("frame_done", int'(frame_done), int'(m_pos == int'(FRAME) - 1));
      check("de", int'(de), int'(vis_pos(d)));
      check("pixel", int'(pixel), vis_pos(d) ? mem_at(addr_pos(d)) : 0);
      check("hsync", int'(hsync), int'(!(d >= 0 && (d % H_TOT) >= 10 && (d % H_TOT) <= 11)));
      check("vsync", int'(vsync), int'(!(d >= 0 && (d / H_TOT) == 5)));
    end
  end

  task automatic wait_fd(input string name);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      hit = frame_done;
    end
    check(name, int'(hit), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"}, int'(sram_rd_en), 0);
    check({tag, "_addr"}, int'(sram_addr), 0);
    check({tag, "_de"}, int'(de), 0);
    check({tag, "_pixel"}, int'(pixel), 0);
    check({tag, "_hsync"}, int'(hsync), 1);
    check({tag, "_vsync"}, int'(vsync), 1);
    check({tag, "_frame_done"}, int'(frame_done), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd_cnt, hs_cnt, vs_cnt, fd_at, seq_err, de_cnt, fd_cnt;
    bit hit;
    rst = 1'b1;
    en  = 1'b0;
    rdy = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    rst = 1'b0;
    repeat (2) @(negedge clk);
    en  = 1'b1;
    rdy = 1'b1;
    @(negedge clk);
    check("start_rd_en", int'(sram_rd_en), 1);
    check("start_addr", int'(sram_addr), 0);
    repeat (2) begin
      @(negedge clk);
      check("early_de", int'(de), 0);
    end
    @(negedge clk);
    check("first_de", int'(de), 1);
    check("first_pixel", int'(pixel), 8'hA5);
    @(negedge clk);
    check("second_pixel", int'(pixel), 8'hA4);

    // One full frame between consecutive frame_done pulses.
    wait_fd("fd_first");
    rd_cnt = 0; hs_cnt = 0; vs_cnt = 0; fd_at = -1; seq_err = 0;
    for (int i = 1; i <= int'(FRAME); i++) begin
      @(negedge clk);
      if (sram_rd_en) begin
        if (int'(sram_addr) != rd_cnt) seq_err++;
        rd_cnt++;
      end
      if (!hsync) hs_cnt++;
      if (!vsync) vs_cnt++;
      if (frame_done && fd_at < 0) fd_at = i;
    end
    check("frame_rd_count", rd_cnt, 32);
    check("frame_addr_seq_errors", seq_err, 0);
    check("frame_hsync_low", hs_cnt, 14);
    check("frame_vsync_low", vs_cnt, 14);
    check("frame_done_period", fd_at, 98);

    // Enable dropped mid-frame: frame completes, then no further reads.
    repeat (20) @(negedge clk);
    en = 1'b0;
    wait_fd("fd_after_drop");
    rd_cnt = 0; fd_cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (sram_rd_en) rd_cnt++;
      if (frame_done) fd_cnt++;
    end
    check("idle_rd_count", rd_cnt, 0);
    check("idle_fd_count", fd_cnt, 0);

    // Enabled without a ready frame: wait, then start right after ready.
    en  = 1'b1;
    rdy = 1'b0;
    rd_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (sram_rd_en) rd_cnt++;
    end
    check("wait_rd_count", rd_cnt, 0);
    rdy = 1'b1;
    @(negedge clk);
    check("ready_start_rd_en", int'(sram_rd_en), 1);
    check("ready_start_addr", int'(sram_addr), 0);

    // Reset in the middle of visible line 2.
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      hit = sram_rd_en && (sram_addr == 19'd18);
    end
    check("reach_line2", int'(hit), 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreset");
    rst = 1'b0;
    en  = 1'b0;
    de_cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (de) de_cnt++;
    end
    check("stale_de_count", de_cnt, 0);
    en  = 1'b1;
    rdy = 1'b1;
    @(negedge clk);
    check("restart_rd_en", int'(sram_rd_en), 1);
    check("restart_addr", int'(sram_addr), 0);
    repeat (2) begin
      @(negedge clk);
      check("restart_early_de", int'(de), 0);
    end
    @(negedge clk);
    check("restart_de", int'(de), 1);
    check("restart_pixel", int'(pixel), 8'hA5);

    repeat (120) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
